video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Consumes the 31.5 MHz pixel clock and PLL lock indication produced by the clock block.
- Generates the 640x480@72Hz raster timing: counters, sync pulses, blanking and frame/line strobes.
- Holds the raster idle until lock has been stable for a qualification period.
- Feeds the pixel fetch and serializer logic downstream.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 24, horizontal front porch (pixels)
H_SYNC, 40, horizontal sync width (pixels)
H_BACK, 128, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 9, vertical front porch (lines)
V_SYNC, 3, vertical sync width (lines)
V_BACK, 28, vertical back porch (lines)
SYNC_ACTIVE_LOW, 1, 1 = sync pulses drive 0 when asserted
LOCK_DELAY, 16, consecutive locked cycles required before raster starts (>=1)

Ports:
clock  input  1  pixel clock (PLL output)
reset  input  1  synchronous, active-high reset
locked  input  1  PLL lock indication, synchronous to clock
running  output  1  raster active (lock qualified)
hsync  output  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
vsync  output  1  vertical sync, polarity per SYNC_ACTIVE_LOW
active  output  1  high when pixel (x,y) is in the visible region
x  output  10  horizontal counter, 0..H_TOTAL-1
y  output  10  vertical counter, 0..V_TOTAL-1
line_start  output  1  one-cycle pulse at x==0
frame_start  output  1  one-cycle pulse at x==0, y==0

Behaviour:
- One clock and one reset. Reset is synchronous and active-high. Ports are named clock and reset.
- Totals: H_TOTAL = sum of the H_* parameters (default 832). V_TOTAL = sum of the V_* parameters (default 520). Counters are 10 bits; totals must be <=1024.
- Reset values:
  - running=0, x=0, y=0, active=0, line_start=0, frame_start=0.
  - hsync and vsync at their deasserted level: 1 when SYNC_ACTIVE_LOW=1, else 0.
  - Lock counter = 0, FSM = WAIT_LOCK.
- FSM states:
  - WAIT_LOCK:
    - locked=1 increments the lock counter; locked=0 clears it.
    - When the counter reaches LOCK_DELAY-1 while locked=1, go to RUN on the next edge.
    - x/y are held at 0; all strobes are 0; syncs are deasserted.
  - RUN:
    - running=1.
    - x increments every cycle and wraps H_TOTAL-1 -> 0.
    - On that wrap, y increments and wraps V_TOTAL-1 -> 0.
  - Loss of lock: locked=0 in RUN -> next edge returns to WAIT_LOCK. Counters, strobes and syncs take their reset values; no partial-frame completion.
- Output alignment:
  - All outputs are registered and describe the same (x,y) on the same cycle. No relative skew between x, y, syncs, active and strobes.
  - The first RUN cycle presents x=0, y=0 with frame_start=1 and line_start=1.
- Output definitions (RUN only):
  - active = (x < H_VISIBLE) && (y < V_VISIBLE).
  - hsync asserted when H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC.
  - vsync asserted for every x on lines V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC. vsync changes only on line boundaries, aligned with x==0.
  - line_start=1 iff x==0. frame_start=1 iff x==0 && y==0.
- Simultaneous events:
  - reset has priority over locked.
  - A lock loss on the cycle of an x/y wrap still forces WAIT_LOCK.
- Reset mid-frame: next cycle shows reset values; re-qualification requires the full LOCK_DELAY.

Test Plan:
- Lock qualification: reset 2 cycles, then locked=1 continuously -> running rises after exactly 16 locked cycles; first RUN cycle has x=0, y=0, frame_start=1.
- Lock glitch during qualification: locked=1 for 10 cycles, 0 for 1, then 1 -> running rises 16 cycles after the glitch, not earlier.
- Horizontal timing, defaults:
  - hsync=0 exactly for x=664..703 (40 cycles); active=1 for x=0..639 on y<480.
  - line_start period is 832 cycles.
- Vertical timing, defaults:
  - vsync=0 for y=489..491 inclusive (3*832 = 2496 cycles).
  - active=0 for all y>=480.
  - frame_start period is 432640 cycles; y wraps 519 -> 0.
- Lock loss mid-frame: locked deasserted at x=300, y=200 -> next cycle running=0, x=0, y=0, hsync=vsync=1. Relock restarts at a clean frame_start after 16 cycles.
- Polarity and reset: SYNC_ACTIVE_LOW=0, reset asserted at x=700, y=490 -> next cycle hsync=vsync=0, running=0; syncs pulse high in the same windows after relock.

Source files
------------

// File: rtl/video_timing_if.sv
// Raster timing bundle driven by video_timing_gen towards pixel fetch and serializer logic.
// x/y, syncs, active and strobes always describe the same pixel on the same cycle.
interface video_timing_if;
   logic       running;
   logic       hsync;
   logic       vsync;
   logic       active;
   logic [9:0] x;
   logic [9:0] y;
   logic       line_start;
   logic       frame_start;

   modport master (
      output running, hsync, vsync, active, x, y, line_start, frame_start
   );
   modport slave (
      input running, hsync, vsync, active, x, y, line_start, frame_start
   );
endinterface

// File: rtl/video_timing_gen.sv
// 640x480@72Hz raster timing generator: qualifies PLL lock, then runs x/y counters and
// derives syncs, blanking and line/frame strobes, all registered from the same next (x,y).
module video_timing_gen #(
   parameter int unsigned H_VISIBLE       = 640,
   parameter int unsigned H_FRONT         = 24,
   parameter int unsigned H_SYNC          = 40,
   parameter int unsigned H_BACK          = 128,
   parameter int unsigned V_VISIBLE       = 480,
   parameter int unsigned V_FRONT         = 9,
   parameter int unsigned V_SYNC          = 3,
   parameter int unsigned V_BACK          = 28,
   parameter int unsigned SYNC_ACTIVE_LOW = 1,
   parameter int unsigned LOCK_DELAY      = 16
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           locked,
   video_timing_if.master vid
);

   // Totals must not exceed 1024 so the 10-bit counters cover the whole raster.
   localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
   localparam int unsigned VS_END   = VS_START + V_SYNC;
   localparam int unsigned LOCK_W   = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;

   localparam logic              SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_DELAY - 1);
   localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);

   typedef enum logic [0:0] {StWaitLock, StRun} state_e;

   state_e            state_q;
   logic [LOCK_W-1:0] lock_cnt_q;
   logic [9:0]        x_q, y_q;
   logic              hsync_q, vsync_q, active_q, line_start_q, frame_start_q;

   logic [9:0] x_nxt, y_nxt;
   logic       x_wrap, y_wrap, hs_on, vs_on, act_nxt, go_run;

   // Outputs are decoded from the coordinate about to be registered, so every output lines up
   // with x/y. Outside RUN the next coordinate is (0,0), which is also the first RUN pixel.
   always_comb begin
      x_wrap = (x_q == 10'(H_TOTAL - 1));
      y_wrap = (y_q == 10'(V_TOTAL - 1));
      x_nxt  = '0;
      y_nxt  = '0;
      if (state_q == StRun) begin
         x_nxt = x_wrap ? 10'd0 : x_q + 10'd1;
         if (x_wrap) begin
            y_nxt = y_wrap ? 10'd0 : y_q + 10'd1;
         end else begin
            y_nxt = y_q;
         end
      end
      hs_on   = (x_nxt >= 10'(HS_START)) && (x_nxt < 10'(HS_END));
      vs_on   = (y_nxt >= 10'(VS_START)) && (y_nxt < 10'(VS_END));
      act_nxt = (x_nxt < 10'(H_VISIBLE)) && (y_nxt < 10'(V_VISIBLE));
      go_run  = locked && ((state_q == StRun) || (lock_cnt_q == LOCK_LAST));
   end

   always_ff @(posedge clock) begin
      if (reset || !go_run) begin
         state_q       <= StWaitLock;
         lock_cnt_q    <= (!reset && locked) ? lock_cnt_q + LOCK_ONE : '0;
         x_q           <= '0;
         y_q           <= '0;
         hsync_q       <= SYNC_IDLE;
         vsync_q       <= SYNC_IDLE;
         active_q      <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= StRun;
         lock_cnt_q    <= '0;
         x_q           <= x_nxt;
         y_q           <= y_nxt;
         hsync_q       <= hs_on ^ SYNC_IDLE;
         vsync_q       <= vs_on ^ SYNC_IDLE;
         active_q      <= act_nxt;
         line_start_q  <= (x_nxt == 10'd0);
         frame_start_q <= (x_nxt == 10'd0) && (y_nxt == 10'd0);
      end
   end

   assign vid.running     = (state_q == StRun);
   assign vid.hsync       = hsync_q;
   assign vid.vsync       = vsync_q;
   assign vid.active      = active_q;
   assign vid.x           = x_q;
   assign vid.y           = y_q;
   assign vid.line_start  = line_start_q;
   assign vid.frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 640x480 instance for lock and line timing, plus two reduced-geometry
// instances (32x20 raster, LOCK_DELAY=4) for whole-frame, lock-loss and sync polarity cases.
`timescale 1ns/1ps
module tb_video_timing_gen;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic d_reset, d_locked, s_reset, s_locked, p_reset, p_locked;
   int   vectors = 0;
   int   miscompares = 0;

   video_timing_if d_if ();
   video_timing_if s_if ();
   video_timing_if p_if ();

   video_timing_gen dut (
      .clock  (clock),
      .reset  (d_reset),
      .locked (d_locked),
      .vid    (d_if)
   );

   // Small raster: hsync x=20..25, vsync y=15..16, visible 16x12, active-low syncs.
   video_timing_gen #(
      .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
      .V_VISIBLE(12), .V_FRONT(3), .V_SYNC(2), .V_BACK(3),
      .SYNC_ACTIVE_LOW(1), .LOCK_DELAY(4)
   ) dut_small (
      .clock  (clock),
      .reset  (s_reset),
      .locked (s_locked),
      .vid    (s_if)
   );

   // Same small raster with active-high syncs.
   video_timing_gen #(
      .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
      .V_VISIBLE(12), .V_FRONT(3), .V_SYNC(2), .V_BACK(3),
      .SYNC_ACTIVE_LOW(0), .LOCK_DELAY(4)
   ) dut_pol (
      .clock  (clock),
      .reset  (p_reset),
      .locked (p_locked),
      .vid    (p_if)
   );

   task automatic test_reset();
      d_reset = 1'b1; d_locked = 1'b1;
      s_reset = 1'b1; s_locked = 1'b0;
      p_reset = 1'b1; p_locked = 1'b1;
      repeat (2) @(negedge clock);
      vectors++;
      if (d_if.running !== 1'b0) begin
         miscompares++; $display("FAIL reset_running: got %b, expected 0", d_if.running);
      end
      vectors++;
      if (d_if.x !== 10'd0 || d_if.y !== 10'd0) begin
         miscompares++; $display("FAIL reset_xy: got x=%0d y=%0d, expected 0 0", d_if.x, d_if.y);
      end
      vectors++;
      if ({d_if.hsync, d_if.vsync} !== 2'b11) begin
         miscompares++;
         $display("FAIL reset_syncs: got %b%b, expected 11", d_if.hsync, d_if.vsync);
      end
      vectors++;
      if ({d_if.active, d_if.line_start, d_if.frame_start} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_strobes: got %b%b%b, expected 000",
                  d_if.active, d_if.line_start, d_if.frame_start);
      end
      vectors++;
      if ({s_if.running, s_if.hsync, s_if.vsync} !== 3'b011) begin
         miscompares++;
         $display("FAIL reset_small: got %b%b%b, expected 011",
                  s_if.running, s_if.hsync, s_if.vsync);
      end
      vectors++;
      if ({p_if.running, p_if.hsync, p_if.vsync} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_pol: got %b%b%b, expected 000",
                  p_if.running, p_if.hsync, p_if.vsync);
      end
   endtask

   task automatic test_lock_qual();
      d_reset = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clock);
         vectors++;
         if (d_if.running !== (k == 16)) begin
            miscompares++;
            $display("FAIL qual_running: cycle %0d got %b, expected %b", k, d_if.running, k == 16);
         end
      end
      vectors++;
      if (d_if.x !== 10'd0 || d_if.y !== 10'd0) begin
         miscompares++; $display("FAIL qual_xy: got x=%0d y=%0d, expected 0 0", d_if.x, d_if.y);
      end
      vectors++;
      if ({d_if.frame_start, d_if.line_start, d_if.active, d_if.hsync, d_if.vsync} !== 5'b11111)
      begin
         miscompares++;
         $display("FAIL qual_first: got fs/ls/act/hs/vs=%b%b%b%b%b, expected 11111",
                  d_if.frame_start, d_if.line_start, d_if.active, d_if.hsync, d_if.vsync);
      end
   endtask

   task automatic test_horizontal();
      int   ex = 0, ey = 0, hs_low = 0, last_ls = 0;
      logic exp_hs, exp_act;
      for (int c = 0; c < 2 * 832 + 10; c++) begin
         exp_hs  = !(ex >= 664 && ex < 704);
         exp_act = (ex < 640) && (ey < 480);
         vectors++;
         if (d_if.x !== 10'(ex) || d_if.y !== 10'(ey)) begin
            miscompares++;
            $display("FAIL h_xy: got x=%0d y=%0d, expected x=%0d y=%0d", d_if.x, d_if.y, ex, ey);
         end
         vectors++;
         if (d_if.hsync !== exp_hs) begin
            miscompares++; $display("FAIL h_hsync: x=%0d got %b, expected %b", ex, d_if.hsync, exp_hs);
         end
         vectors++;
         if (d_if.active !== exp_act) begin
            miscompares++;
            $display("FAIL h_active: x=%0d got %b, expected %b", ex, d_if.active, exp_act);
         end
         vectors++;
         if (d_if.line_start !== (ex == 0) || d_if.frame_start !== (ex == 0 && ey == 0)) begin
            miscompares++;
            $display("FAIL h_strobes: x=%0d y=%0d got ls=%b fs=%b", ex, ey, d_if.line_start,
                     d_if.frame_start);
         end
         if (d_if.hsync === 1'b0) hs_low++;
         if (d_if.line_start === 1'b1 && c > 0) begin
            vectors++;
            if (c - last_ls != 832) begin
               miscompares++;
               $display("FAIL h_line_period: got %0d, expected 832", c - last_ls);
            end
            last_ls = c;
         end
         ex++;
         if (ex == 832) begin
            ex = 0;
            ey++;
         end
         @(negedge clock);
      end
      vectors++;
      if (hs_low != 80) begin
         miscompares++; $display("FAIL h_sync_width: got %0d low cycles, expected 80", hs_low);
      end
   endtask

   task automatic test_lock_glitch();
      d_reset = 1'b1;
      @(negedge clock);
      d_reset = 1'b0;
      d_locked = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clock);
         vectors++;
         if (d_if.running !== 1'b0) begin
            miscompares++; $display("FAIL glitch_pre: cycle %0d got %b, expected 0", k, d_if.running);
         end
      end
      d_locked = 1'b0;
      @(negedge clock);
      d_locked = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clock);
         vectors++;
         if (d_if.running !== (k == 16)) begin
            miscompares++;
            $display("FAIL glitch_post: cycle %0d got %b, expected %b", k, d_if.running, k == 16);
         end
      end
      vectors++;
      if (d_if.frame_start !== 1'b1 || d_if.x !== 10'd0) begin
         miscompares++;
         $display("FAIL glitch_first: got fs=%b x=%0d, expected 1 0", d_if.frame_start, d_if.x);
      end
   endtask

   task automatic test_lock_loss();
      repeat (832 + 300) @(negedge clock);
      vectors++;
      if (d_if.x !== 10'd300 || d_if.y !== 10'd1) begin
         miscompares++;
         $display("FAIL loss_pos: got x=%0d y=%0d, expected 300 1", d_if.x, d_if.y);
      end
      d_locked = 1'b0;
      @(negedge clock);
      vectors++;
      if ({d_if.running, d_if.hsync, d_if.vsync, d_if.active} !== 4'b0110 ||
          d_if.x !== 10'd0 || d_if.y !== 10'd0) begin
         miscompares++;
         $display("FAIL loss_state: got run/hs/vs/act=%b%b%b%b x=%0d y=%0d, expected 0110 0 0",
                  d_if.running, d_if.hsync, d_if.vsync, d_if.active, d_if.x, d_if.y);
      end
      d_locked = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clock);
         vectors++;
         if (d_if.running !== (k == 16)) begin
            miscompares++;
            $display("FAIL loss_relock: cycle %0d got %b, expected %b", k, d_if.running, k == 16);
         end
      end
      vectors++;
      if (d_if.frame_start !== 1'b1 || d_if.x !== 10'd0 || d_if.y !== 10'd0) begin
         miscompares++;
         $display("FAIL loss_restart: got fs=%b x=%0d y=%0d, expected 1 0 0",
                  d_if.frame_start, d_if.x, d_if.y);
      end
   endtask

   task automatic test_vertical();
      int   ex = 0, ey = 0, vs_low = 0, last_fs = 0;
      logic exp_hs, exp_vs, exp_act;
      s_reset = 1'b0;
      s_locked = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clock);
         vectors++;
         if (s_if.running !== (k == 4)) begin
            miscompares++;
            $display("FAIL v_qual: cycle %0d got %b, expected %b", k, s_if.running, k == 4);
         end
      end
      for (int c = 0; c < 2 * 640 + 5; c++) begin
         exp_hs  = !(ex >= 20 && ex < 26);
         exp_vs  = !(ey >= 15 && ey < 17);
         exp_act = (ex < 16) && (ey < 12);
         vectors++;
         if (s_if.x !== 10'(ex) || s_if.y !== 10'(ey)) begin
            miscompares++;
            $display("FAIL v_xy: got x=%0d y=%0d, expected x=%0d y=%0d", s_if.x, s_if.y, ex, ey);
         end
         vectors++;
         if (s_if.hsync !== exp_hs || s_if.vsync !== exp_vs) begin
            miscompares++;
            $display("FAIL v_syncs: x=%0d y=%0d got hs=%b vs=%b, expected hs=%b vs=%b",
                     ex, ey, s_if.hsync, s_if.vsync, exp_hs, exp_vs);
         end
         vectors++;
         if (s_if.active !== exp_act) begin
            miscompares++;
            $display("FAIL v_active: x=%0d y=%0d got %b, expected %b", ex, ey, s_if.active, exp_act);
         end
         vectors++;
         if (s_if.frame_start !== (ex == 0 && ey == 0) || s_if.line_start !== (ex == 0)) begin
            miscompares++;
            $display("FAIL v_strobes: x=%0d y=%0d got fs=%b ls=%b", ex, ey, s_if.frame_start,
                     s_if.line_start);
         end
         if (s_if.vsync === 1'b0) vs_low++;
         if (s_if.frame_start === 1'b1 && c > 0) begin
            vectors++;
            if (c - last_fs != 640) begin
               miscompares++;
               $display("FAIL v_frame_period: got %0d, expected 640", c - last_fs);
            end
            last_fs = c;
         end
         ex++;
         if (ex == 32) begin
            ex = 0;
            ey = (ey == 19) ? 0 : ey + 1;
         end
         @(negedge clock);
      end
      vectors++;
      if (vs_low != 128) begin
         miscompares++; $display("FAIL v_sync_width: got %0d low cycles, expected 128", vs_low);
      end
   endtask

   task automatic test_small_lock_loss();
      // Mid-frame loss at (10,7), then a loss coinciding with the x/y wrap at (31,19).
      s_locked = 1'b0;
      @(negedge clock);
      s_locked = 1'b1;
      repeat (4) @(negedge clock);
      vectors++;
      if (s_if.running !== 1'b1 || s_if.frame_start !== 1'b1) begin
         miscompares++;
         $display("FAIL sl_relock: got run=%b fs=%b, expected 1 1", s_if.running, s_if.frame_start);
      end
      repeat (7 * 32 + 10) @(negedge clock);
      vectors++;
      if (s_if.x !== 10'd10 || s_if.y !== 10'd7) begin
         miscompares++; $display("FAIL sl_pos: got x=%0d y=%0d, expected 10 7", s_if.x, s_if.y);
      end
      s_locked = 1'b0;
      @(negedge clock);
      vectors++;
      if ({s_if.running, s_if.hsync, s_if.vsync} !== 3'b011 || s_if.y !== 10'd0) begin
         miscompares++;
         $display("FAIL sl_mid_loss: got run/hs/vs=%b%b%b y=%0d, expected 011 0",
                  s_if.running, s_if.hsync, s_if.vsync, s_if.y);
      end
      s_locked = 1'b1;
      repeat (4 + 639) @(negedge clock);
      vectors++;
      if (s_if.x !== 10'd31 || s_if.y !== 10'd19 || s_if.running !== 1'b1) begin
         miscompares++;
         $display("FAIL sl_wrap_pos: got x=%0d y=%0d run=%b, expected 31 19 1",
                  s_if.x, s_if.y, s_if.running);
      end
      s_locked = 1'b0;
      @(negedge clock);
      vectors++;
      if (s_if.running !== 1'b0 || s_if.frame_start !== 1'b0 || s_if.line_start !== 1'b0) begin
         miscompares++;
         $display("FAIL sl_wrap_loss: got run=%b fs=%b ls=%b, expected 0 0 0",
                  s_if.running, s_if.frame_start, s_if.line_start);
      end
   endtask

   task automatic test_polarity();
      int ex = 0, ey = 0;
      p_reset = 1'b0;
      repeat (4) @(negedge clock);
      for (int c = 0; c < 640; c++) begin
         vectors++;
         if (p_if.hsync !== (ex >= 20 && ex < 26) || p_if.vsync !== (ey >= 15 && ey < 17)) begin
            miscompares++;
            $display("FAIL pol_syncs: x=%0d y=%0d got hs=%b vs=%b", ex, ey, p_if.hsync, p_if.vsync);
         end
         ex++;
         if (ex == 32) begin
            ex = 0;
            ey++;
         end
         @(negedge clock);
      end
      repeat (15 * 32 + 22) @(negedge clock);
      vectors++;
      if (p_if.x !== 10'd22 || p_if.y !== 10'd15 || {p_if.hsync, p_if.vsync} !== 2'b11) begin
         miscompares++;
         $display("FAIL pol_pos: got x=%0d y=%0d hs=%b vs=%b, expected 22 15 1 1",
                  p_if.x, p_if.y, p_if.hsync, p_if.vsync);
      end
      p_reset = 1'b1;
      @(negedge clock);
      vectors++;
      if ({p_if.running, p_if.hsync, p_if.vsync} !== 3'b000 || p_if.x !== 10'd0) begin
         miscompares++;
         $display("FAIL pol_reset: got run/hs/vs=%b%b%b x=%0d, expected 000 0",
                  p_if.running, p_if.hsync, p_if.vsync, p_if.x);
      end
      p_reset = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clock);
         vectors++;
         if (p_if.running !== (k == 4)) begin
            miscompares++;
            $display("FAIL pol_requal: cycle %0d got %b, expected %b", k, p_if.running, k == 4);
         end
      end
      repeat (15 * 32 + 22) @(negedge clock);
      vectors++;
      if ({p_if.hsync, p_if.vsync} !== 2'b11 || p_if.x !== 10'd22) begin
         miscompares++;
         $display("FAIL pol_after: got hs=%b vs=%b x=%0d, expected 1 1 22",
                  p_if.hsync, p_if.vsync, p_if.x);
      end
   endtask

   initial begin
      test_reset();
      test_lock_qual();
      test_horizontal();
      test_lock_glitch();
      test_lock_loss();
      test_vertical();
      test_small_lock_loss();
      test_polarity();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
